// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fetch_pkg
//  Description : Shared types and constants for the program-fetch controller.
//                - fetch_state_t : controller state encoding
//                - HALT_CODE_DEFAULT : machine word that ends a program
//                - OFF_W : width of the signed relative-branch offset
//  Revision    : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int OFF_W = 8;

  localparam logic [8:0] HALT_CODE_DEFAULT = 9'b111111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_branch_target.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target
//  Description : Combinational branch-target calculator.
//                Absolute: target = br_target.
//                Relative: target = instr_pc + sign-extended br_offset,
//                modulo 2^D (wrap-around is legal).
//  Ports       : br_abs     in  1      select absolute target
//                br_target  in  D      absolute target address
//                br_offset  in  OFF_W  signed relative offset
//                instr_pc   in  D      address of the branching instruction
//                target     out D      resulting fetch address
//  Revision    : 1.0  initial release
// ============================================================================
module branch_target
  import fetch_pkg::*;
#(
  parameter int D = 12
) (
  input  logic             br_abs,
  input  logic [D-1:0]     br_target,
  input  logic [OFF_W-1:0] br_offset,
  input  logic [D-1:0]     instr_pc,
  output logic [D-1:0]     target
);

  logic [D-1:0] offset_sext;

  assign offset_sext = {{(D - OFF_W){br_offset[OFF_W-1]}}, br_offset};

  // Natural D-bit truncation gives the modulo-2^D wrap.
  assign target = br_abs ? br_target : (instr_pc + offset_sext);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Program-fetch controller for the 9-bit instruction ROM.
//                Owns the PC, drives the ROM address, captures each word into
//                a one-entry instruction register handed to the decoder via
//                valid/ready, applies taken branches, detects the halt word
//                and reports busy/done.
//  Ports       : Clk          in  1  system clock
//                Reset        in  1  synchronous active-high reset
//                start        in  1  begin execution (IDLE/DONE only)
//                prog_ctr     out D  ROM address
//                mach_code    in  9  ROM data (combinational from prog_ctr)
//                instr        out 9  instruction register
//                instr_pc     out D  address instr was fetched from
//                instr_valid  out 1  instr holds an unconsumed word
//                instr_ready  in  1  decoder accepts instr
//                br_taken     in  1  redirect (sampled on consume in RUN)
//                br_abs       in  1  absolute (1) / relative (0) target
//                br_target    in  D  absolute target
//                br_offset    in  8  signed relative offset
//                busy         out 1  RUN or DRAIN
//                done         out 1  halt word consumed
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int         D         = 12,
  parameter logic [D-1:0] PC_START  = '0,
  parameter logic [8:0] HALT_CODE = HALT_CODE_DEFAULT
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  output logic [D-1:0]     prog_ctr,
  input  logic [8:0]       mach_code,
  output logic [8:0]       instr,
  output logic [D-1:0]     instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             br_taken,
  input  logic             br_abs,
  input  logic [D-1:0]     br_target,
  input  logic [OFF_W-1:0] br_offset,
  output logic             busy,
  output logic             done
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [D-1:0] pc;
  logic [D-1:0] br_tgt;
  logic         consume;
  logic         take_branch;
  logic         fetch_en;
  logic         is_halt;
  logic         busy_next;
  logic         done_next;

  branch_target #(.D(D)) u_branch_target (
    .br_abs    (br_abs),
    .br_target (br_target),
    .br_offset (br_offset),
    .instr_pc  (instr_pc),
    .target    (br_tgt)
  );

  assign prog_ctr = pc;
  assign consume  = instr_valid & instr_ready;
  assign is_halt  = (mach_code == HALT_CODE);

  // Next-state and fetch enable. A taken branch suppresses the same-cycle
  // fetch, which is also how it beats a halt word sitting at the ROM output.
  always_comb begin
    take_branch = (state == RUN) & consume & br_taken;
    fetch_en    = (state == RUN) & (~instr_valid | consume) & ~take_branch;
    state_next  = state;
    unique case (state)
      IDLE:  if (start)               state_next = RUN;
      RUN:   if (fetch_en && is_halt) state_next = DRAIN;
      DRAIN: if (consume)             state_next = DONE;
      DONE:  if (start)               state_next = RUN;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_comb begin
    busy_next = (state_next == RUN) || (state_next == DRAIN);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= PC_START;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      done  <= done_next;
      if ((state == IDLE) || ((state == DONE) && start)) begin
        pc <= PC_START;
      end else if (take_branch) begin
        pc          <= br_tgt;
        instr_valid <= 1'b0;
      end else if (fetch_en) begin
        instr       <= mach_code;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 1'b1;
      end else if ((state == DRAIN) && consume) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. A behavioural
//                program-fetch model tracks the expected outputs every cycle;
//                directed scenarios are followed by randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int         D    = 12;
  localparam int         NPC  = 4096;
  localparam logic [8:0] HALT = 9'h1FF;

  logic          Clk;
  logic          Reset;
  logic          start;
  logic [D-1:0]  prog_ctr;
  logic [8:0]    mach_code;
  logic [8:0]    instr;
  logic [D-1:0]  instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          br_taken;
  logic          br_abs;
  logic [D-1:0]  br_target;
  logic [7:0]    br_offset;
  logic          busy;
  logic          done;

  logic [8:0] rom [0:NPC-1];

  int tests = 0;
  int fails = 0;

  // Reference model state (program level: running / halt pending / done)
  int         m_pc;
  logic [8:0] m_ir;
  int         m_ir_pc;
  logic       m_valid;
  logic       m_running;
  logic       m_halt_seen;
  logic       m_done;

  fetch_sequencer dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .prog_ctr    (prog_ctr),
    .mach_code   (mach_code),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_abs      (br_abs),
    .br_target   (br_target),
    .br_offset   (br_offset),
    .busy        (busy),
    .done        (done)
  );

  assign mach_code = rom[prog_ctr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = '0; m_ir_pc = 0; m_valid = 1'b0;
    m_running = 1'b0; m_halt_seen = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_update();
    logic cons;
    int   t;
    if (Reset) begin
      model_reset();
    end else begin
      cons = m_valid && instr_ready;
      if (!m_running) begin
        if (start) begin
          m_running = 1'b1; m_done = 1'b0; m_pc = 0;
        end else if (!m_done) begin
          m_pc = 0;
        end
      end else if (!m_halt_seen) begin
        if (cons && br_taken) begin
          if (br_abs) t = int'(br_target);
          else        t = ((m_ir_pc + int'($signed(br_offset))) % NPC + NPC) % NPC;
          m_pc    = t;
          m_valid = 1'b0;
        end else if (!m_valid || cons) begin
          m_ir    = rom[m_pc];
          m_ir_pc = m_pc;
          m_valid = 1'b1;
          m_pc    = (m_pc + 1) % NPC;
          if (m_ir == HALT) m_halt_seen = 1'b1;
        end
      end else if (cons) begin
        m_valid = 1'b0; m_running = 1'b0; m_halt_seen = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("prog_ctr",    32'(prog_ctr),    32'(m_pc));
    chk("instr",       32'(instr),       32'(m_ir));
    chk("instr_pc",    32'(instr_pc),    32'(m_ir_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("busy",        32'(busy),        32'(m_running));
    chk("done",        32'(done),        32'(m_done));
  endtask

  // One clock: model follows the inputs held across the edge, then compare.
  task automatic step();
    @(posedge Clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic fill_rom_plain();
    for (int i = 0; i < NPC; i++) rom[i] = 9'((i * 7 + 3) % 256);
  endtask

  // Run until the instruction at pc_at is consumed with a taken branch,
  // then check the bubble and the landing address.
  task automatic run_branch(input int pc_at, input logic abs, input int tgt,
                            input logic [7:0] off, input int exp_pc);
    logic fired;
    fired = 1'b0;
    br_abs    = abs;
    br_target = D'(tgt);
    br_offset = off;
    for (int i = 0; i < 200 && !fired; i++) begin
      br_taken = m_valid && (m_ir_pc == pc_at) && instr_ready;
      fired    = br_taken;
      step();
    end
    br_taken = 1'b0;
    chk("branch_reached", 32'(fired), 32'd1);
    chk("branch_bubble", 32'(instr_valid), 32'd0);
    step();
    chk("branch_valid", 32'(instr_valid), 32'd1);
    chk("branch_dest", 32'(instr_pc), 32'(exp_pc));
  endtask

  initial begin
    model_reset();
    Reset = 1'b1; start = 1'b0; instr_ready = 1'b1;
    br_taken = 1'b0; br_abs = 1'b0; br_target = '0; br_offset = '0;
    fill_rom_plain();
    rom[0] = 9'h03E; rom[1] = 9'h0CC; rom[2] = 9'h0F4; rom[3] = HALT;

    // Reset state
    step(); step();
    Reset = 1'b0;
    chk("rst_prog_ctr", 32'(prog_ctr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Straight line: cycles 2..5 carry the program, done in cycle 6
    start = 1'b1; step(); start = 1'b0;
    chk("sl_pc_c1", 32'(prog_ctr), 32'd0);
    step(); chk("sl_i0", 32'(instr), 32'h03E);
    step(); chk("sl_i1", 32'(instr), 32'h0CC);
    step(); chk("sl_i2", 32'(instr), 32'h0F4);
    step(); chk("sl_i3", 32'(instr), 32'h1FF);
    chk("sl_busy_drain", 32'(busy), 32'd1);
    step(); chk("sl_done", 32'(done), 32'd1);
    chk("sl_busy", 32'(busy), 32'd0);
    step(); chk("sl_done_hold", 32'(done), 32'd1);

    // Restart from DONE, then backpressure on 0x0CC
    start = 1'b1; step(); start = 1'b0;
    chk("rs_done_clr", 32'(done), 32'd0);
    step(); chk("rs_i0", 32'(instr), 32'h03E);
    step(); chk("bp_i1", 32'(instr), 32'h0CC);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_instr", 32'(instr), 32'h0CC);
      chk("bp_instr_pc", 32'(instr_pc), 32'd1);
      chk("bp_prog_ctr", 32'(prog_ctr), 32'd2);
    end
    instr_ready = 1'b1;
    step(); chk("bp_next", 32'(instr), 32'h0F4);
    chk("bp_next_pc", 32'(instr_pc), 32'd2);
    step(); step();
    chk("bp_done", 32'(done), 32'd1);

    // Branches: relative back, absolute to top of memory, relative wrap
    fill_rom_plain();
    Reset = 1'b1; step(); Reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    run_branch(10, 1'b0, 0, 8'hFC, 6);
    run_branch(8, 1'b1, 4094, 8'h00, 4094);
    run_branch(4094, 1'b0, 0, 8'h05, 3);

    // Absolute branch coinciding with a halt word at the ROM output
    rom[5] = HALT;
    Reset = 1'b1; step(); Reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    run_branch(4, 1'b1, 32'h020, 8'h00, 32'h020);
    chk("bh_not_done", 32'(done), 32'd0);
    chk("bh_busy", 32'(busy), 32'd1);
    rom[5] = 9'h005;

    // start ignored while RUN, then reset mid-run
    start = 1'b1; step(); start = 1'b0;
    chk("run_start_ign", 32'(instr_pc), 32'h021);
    Reset = 1'b1; step(); Reset = 1'b0;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", 32'(prog_ctr), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < NPC; i++)
      rom[i] = ($urandom_range(0, 19) == 0) ? HALT : 9'($urandom_range(0, 510));
    for (int c = 0; c < 4000; c++) begin
      Reset       = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 9) == 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 5) == 0);
      br_abs      = 1'($urandom_range(0, 1));
      br_target   = D'($urandom_range(0, NPC - 1));
      br_offset   = 8'($urandom_range(0, 255));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
